// File: rtl/flash_phy_rd_buf_ctrl_if.sv
// Request/response, program and buffer-status bundle between the flash_phy read
// arbiter side and the read-buffer control stage.
interface flash_phy_rd_buf_ctrl_if #(
  parameter int NumBuf   = 4,
  parameter int AddrW    = 16,
  parameter int InfoSelW = 2
);
  logic                                 en_i;
  logic                                 req_i;
  logic [AddrW-1:0]                     req_addr_i;
  logic                                 req_part_i;
  logic [InfoSelW-1:0]                  req_info_sel_i;
  logic                                 req_ready_o;
  logic                                 hit_o;
  logic [$clog2(NumBuf)-1:0]            hit_idx_o;
  logic                                 rd_issue_o;
  logic                                 rsp_valid_i;
  logic                                 prog_i;
  logic [AddrW-1:0]                     prog_addr_i;
  logic                                 prog_part_i;
  logic [InfoSelW-1:0]                  prog_info_sel_i;
  logic [NumBuf-1:0][1:0]               buf_attr_i;
  logic [NumBuf-1:0][AddrW-1:0]         buf_addr_i;
  logic [NumBuf-1:0]                    buf_part_i;
  logic [NumBuf-1:0][InfoSelW-1:0]      buf_info_sel_i;
  logic [NumBuf-1:0]                    alloc_o;
  logic [NumBuf-1:0]                    update_o;
  logic [NumBuf-1:0]                    wipe_o;

  modport slave (
    input  en_i, req_i, req_addr_i, req_part_i, req_info_sel_i, rsp_valid_i,
           prog_i, prog_addr_i, prog_part_i, prog_info_sel_i,
           buf_attr_i, buf_addr_i, buf_part_i, buf_info_sel_i,
    output req_ready_o, hit_o, hit_idx_o, rd_issue_o, alloc_o, update_o, wipe_o
  );

  modport master (
    output en_i, req_i, req_addr_i, req_part_i, req_info_sel_i, rsp_valid_i,
           prog_i, prog_addr_i, prog_part_i, prog_info_sel_i,
           buf_attr_i, buf_addr_i, buf_part_i, buf_info_sel_i,
    input  req_ready_o, hit_o, hit_idx_o, rd_issue_o, alloc_o, update_o, wipe_o
  );
endinterface

// File: rtl/flash_phy_rd_buf_ctrl.sv
// Read-buffer control: tag lookup, LRU victim selection, alloc/update/wipe strobes
// and an in-order tracker of outstanding flash reads.
module flash_phy_rd_buf_ctrl_lane #(
  parameter int AddrW    = 16,
  parameter int InfoSelW = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [1:0]          attr_i,
  input  logic [AddrW-1:0]    addr_i,
  input  logic                part_i,
  input  logic [InfoSelW-1:0] info_sel_i,
  input  logic [AddrW-1:0]    req_addr_i,
  input  logic                req_part_i,
  input  logic [InfoSelW-1:0] req_info_sel_i,
  input  logic                prog_i,
  input  logic [AddrW-1:0]    prog_addr_i,
  input  logic                prog_part_i,
  input  logic [InfoSelW-1:0] prog_info_sel_i,
  input  logic                update_i,
  output logic                req_match_o,
  output logic                wipe_o,
  output logic                busy_o
);
  localparam logic [1:0] AttrInvalid = 2'd0;
  localparam logic [1:0] AttrWip     = 2'd1;
  localparam logic [1:0] AttrValid   = 2'd2;

  logic live, prog_eq, req_eq, pend_set;
  logic pend_q, pend_d, fire_q, fire_d;

  assign live    = attr_i != AttrInvalid;
  assign req_eq  = (addr_i == req_addr_i) && (part_i == req_part_i) &&
                   (!part_i || (info_sel_i == req_info_sel_i));
  assign prog_eq = (addr_i == prog_addr_i) && (part_i == prog_part_i) &&
                   (!part_i || (info_sel_i == prog_info_sel_i));

  assign req_match_o = live && req_eq;

  // A program hitting an in-flight buffer is deferred until its data lands.
  always_comb begin
    pend_set = en_i && prog_i && prog_eq && (attr_i == AttrWip);
    pend_d   = en_i && (pend_q || pend_set) && !update_i;
    fire_d   = en_i && (pend_q || pend_set) && update_i;
  end

  assign wipe_o = en_i && ((prog_i && prog_eq && (attr_i == AttrValid)) || fire_q);
  assign busy_o = pend_q || fire_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      fire_q <= fire_d;
    end
  end
endmodule

module flash_phy_rd_buf_ctrl #(
  parameter int NumBuf   = 4,
  parameter int AddrW    = 16,
  parameter int InfoSelW = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  flash_phy_rd_buf_ctrl_if.slave bus
);
  localparam int IdxW = $clog2(NumBuf);
  localparam int CntW = IdxW + 1;
  localparam logic [1:0] AttrInvalid = 2'd0;
  localparam logic [1:0] AttrWip     = 2'd1;
  localparam logic [1:0] AttrValid   = 2'd2;

  logic [NumBuf-1:0] req_match, busy, lane_wipe, is_inv, is_wip, is_valid, upd;

  for (genvar g = 0; g < NumBuf; g++) begin : g_lane
    assign is_inv[g]   = bus.buf_attr_i[g] == AttrInvalid;
    assign is_wip[g]   = bus.buf_attr_i[g] == AttrWip;
    assign is_valid[g] = bus.buf_attr_i[g] == AttrValid;

    flash_phy_rd_buf_ctrl_lane #(.AddrW(AddrW), .InfoSelW(InfoSelW)) u_lane (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .en_i           (bus.en_i),
      .attr_i         (bus.buf_attr_i[g]),
      .addr_i         (bus.buf_addr_i[g]),
      .part_i         (bus.buf_part_i[g]),
      .info_sel_i     (bus.buf_info_sel_i[g]),
      .req_addr_i     (bus.req_addr_i),
      .req_part_i     (bus.req_part_i),
      .req_info_sel_i (bus.req_info_sel_i),
      .prog_i         (bus.prog_i),
      .prog_addr_i    (bus.prog_addr_i),
      .prog_part_i    (bus.prog_part_i),
      .prog_info_sel_i(bus.prog_info_sel_i),
      .update_i       (upd[g]),
      .req_match_o    (req_match[g]),
      .wipe_o         (lane_wipe[g]),
      .busy_o         (busy[g])
    );
  end

  logic [NumBuf-1:0][IdxW-1:0] age_q, age_d;
  logic [NumBuf-1:0][IdxW-1:0] fifo_q, fifo_d;
  logic [IdxW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;

  logic            hit_vld, blk, vic_vld, fifo_full, ready, accept, hit, issue, push, pop;
  logic [IdxW-1:0] hit_idx, vic_idx, vic_age, touch_idx;

  // Lookup and victim choice; buffers with a deferred wipe are never reused.
  always_comb begin
    hit_vld = 1'b0;
    hit_idx = '0;
    blk     = 1'b0;
    vic_vld = 1'b0;
    vic_idx = '0;
    vic_age = '0;
    for (int i = 0; i < NumBuf; i++) begin
      if (req_match[i] && is_wip[i]) blk = 1'b1;
      if (req_match[i] && is_valid[i] && !hit_vld) begin
        hit_vld = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    for (int i = 0; i < NumBuf; i++) begin
      if (is_inv[i] && !busy[i] && !vic_vld) begin
        vic_vld = 1'b1;
        vic_idx = IdxW'(i);
      end
    end
    if (!vic_vld) begin
      for (int i = 0; i < NumBuf; i++) begin
        if (is_valid[i] && !busy[i] && (!vic_vld || (age_q[i] > vic_age))) begin
          vic_vld = 1'b1;
          vic_idx = IdxW'(i);
          vic_age = age_q[i];
        end
      end
    end
  end

  always_comb begin
    fifo_full = cnt_q == CntW'(NumBuf);
    if (!bus.en_i)     ready = 1'b1;
    else if (bus.prog_i) ready = 1'b0;
    else if (blk)      ready = 1'b0;
    else if (hit_vld)  ready = 1'b1;
    else               ready = !fifo_full && vic_vld;
    accept    = bus.en_i && bus.req_i && ready;
    hit       = accept && hit_vld;
    issue     = accept && !hit_vld;
    touch_idx = hit_vld ? hit_idx : vic_idx;
    push      = issue;
    pop       = bus.en_i && bus.rsp_valid_i && (cnt_q != '0);
    upd       = pop ? (NumBuf'(1) << fifo_q[rd_ptr_q]) : '0;
  end

  assign bus.req_ready_o = ready;
  assign bus.hit_o       = hit;
  assign bus.hit_idx_o   = hit ? hit_idx : '0;
  assign bus.rd_issue_o  = issue;
  assign bus.alloc_o     = issue ? (NumBuf'(1) << vic_idx) : '0;
  assign bus.update_o    = upd;
  assign bus.wipe_o      = lane_wipe;

  // Move-to-front LRU; ages stay a permutation of 0..NumBuf-1.
  always_comb begin
    age_d = age_q;
    if (hit || issue) begin
      for (int j = 0; j < NumBuf; j++) begin
        if (age_q[j] < age_q[touch_idx]) age_d[j] = age_q[j] + IdxW'(1);
      end
      age_d[touch_idx] = '0;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (!bus.en_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = vic_idx;
        wr_ptr_d         = wr_ptr_q + IdxW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + IdxW'(1);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBuf; i++) age_q[i] <= IdxW'(i);
      fifo_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      age_q    <= age_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  rsp_without_read_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.en_i && bus.rsp_valid_i) |-> (cnt_q != '0));
endmodule
